// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding
// and the register-index width.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the
// instruction sitting in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             hazard
);

    logic hit1;
    logic hit2;

    assign hit1   = id_use_rs1 && (ex_rd == id_rs1);
    assign hit2   = id_use_rs2 && (ex_rd == id_rs2);
    assign hazard = ex_memread && (ex_rd != '0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller. Define PIPE_CTRL_MUL_STALL_EN
// to hold a multiply in EX for MUL_LAT cycles; otherwise it takes one.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] ID_RS1,
    input  logic [REG_W-1:0] ID_RS2,
    input  logic             ID_USE_RS1,
    input  logic             ID_USE_RS2,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             EX_MEMREAD,
    input  logic             EX_BR_TAKEN,
    input  logic             EX_IS_MUL,
    input  logic             DMEM_BUSY,
    input  logic             WB_HALT,
    output logic             PC_WREN,
    output logic             IFID_WREN,
    output logic             IDEX_WREN,
    output logic             EXMEM_WREN,
    output logic             MEMWB_WREN,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic [31:0]      STALL_CNT,
    output logic             HALTED
);

    state_t      state;
    state_t      state_n;
    logic [31:0] stall_q;
    logic [4:0]  wren;
    logic [2:0]  flush;
    logic        hazard;
    logic        halting;
    logic        stall_inc;

`ifdef PIPE_CTRL_MUL_STALL_EN
    logic [3:0] mul_cnt;
    logic [3:0] mul_cnt_n;
`else
    logic unused_mul;
    assign unused_mul = &{1'b0, EX_IS_MUL, 4'(MUL_LAT)};
`endif

    hazard_detect u_hazard (
        .ex_rd      (EX_RD),
        .ex_memread (EX_MEMREAD),
        .id_rs1     (ID_RS1),
        .id_rs2     (ID_RS2),
        .id_use_rs1 (ID_USE_RS1),
        .id_use_rs2 (ID_USE_RS2),
        .hazard     (hazard)
    );

    assign halting   = (state == HALT) || WB_HALT;
    assign stall_inc = !halting && !wren[4];

    // wren = {PC, IFID, IDEX, EXMEM, MEMWB}; flush = {IFID, IDEX, EXMEM}
    always_comb begin
        wren    = '1;
        flush   = '0;
        state_n = state;
`ifdef PIPE_CTRL_MUL_STALL_EN
        mul_cnt_n = mul_cnt;
`endif
        if (halting) begin
            wren    = '0;
            state_n = HALT;
        end else if (DMEM_BUSY) begin
            wren = '0;
`ifdef PIPE_CTRL_MUL_STALL_EN
        end else if (state == MUL_BUSY) begin
            if (mul_cnt != 4'd0) begin
                wren      = 5'b00011;
                flush     = 3'b001;
                mul_cnt_n = mul_cnt - 4'd1;
            end else begin
                state_n = RUN;
            end
        end else if (EX_IS_MUL) begin
            wren      = 5'b00011;
            flush     = 3'b001;
            state_n   = MUL_BUSY;
            mul_cnt_n = 4'(MUL_LAT - 2);
`endif
        end else if (EX_BR_TAKEN) begin
            flush = 3'b110;
        end else if (hazard) begin
            wren  = 5'b00111;
            flush = 3'b010;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            stall_q <= '0;
`ifdef PIPE_CTRL_MUL_STALL_EN
            mul_cnt <= '0;
`endif
        end else begin
            state <= state_n;
`ifdef PIPE_CTRL_MUL_STALL_EN
            mul_cnt <= mul_cnt_n;
`endif
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign {PC_WREN, IFID_WREN, IDEX_WREN, EXMEM_WREN, MEMWB_WREN} = wren;
    assign {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH} = flush;
    assign STALL_CNT = stall_q;
    assign HALTED    = (state == HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int MUL_LAT = 3;
`ifdef PIPE_CTRL_MUL_STALL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [4:0]  ID_RS1 = '0;
    logic [4:0]  ID_RS2 = '0;
    logic        ID_USE_RS1 = 1'b0;
    logic        ID_USE_RS2 = 1'b0;
    logic [4:0]  EX_RD = '0;
    logic        EX_MEMREAD = 1'b0;
    logic        EX_BR_TAKEN = 1'b0;
    logic        EX_IS_MUL = 1'b0;
    logic        DMEM_BUSY = 1'b0;
    logic        WB_HALT = 1'b0;
    logic        PC_WREN, IFID_WREN, IDEX_WREN, EXMEM_WREN, MEMWB_WREN;
    logic        IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH;
    logic [31:0] STALL_CNT;
    logic        HALTED;

    pipe_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
        .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD),
        .EX_BR_TAKEN(EX_BR_TAKEN), .EX_IS_MUL(EX_IS_MUL),
        .DMEM_BUSY(DMEM_BUSY), .WB_HALT(WB_HALT),
        .PC_WREN(PC_WREN), .IFID_WREN(IFID_WREN),
        .IDEX_WREN(IDEX_WREN), .EXMEM_WREN(EXMEM_WREN),
        .MEMWB_WREN(MEMWB_WREN),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
        .EXMEM_FLUSH(EXMEM_FLUSH),
        .STALL_CNT(STALL_CNT), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        bit       rst, wbh, dm, mul, br, mr;
        bit [4:0] rd, rs1, rs2;
        bit       u1, u2;
    } stim_t;

    typedef struct {
        bit          skip;
        logic [4:0]  wren;
        logic [2:0]  flush;
        logic [31:0] stall;
        logic        halted;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    bit          m_halt = 1'b0;
    int          m_mul_left = 0;
    logic [31:0] m_stall = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: m_mul_left counts EX cycles the multiply still needs.
    task automatic step(input stim_t s, input bit pre = 1'b0);
        exp_t e;
        bit   hz;
        bit   st;
        @(posedge CLK);
        #1;
        RST = s.rst; WB_HALT = s.wbh; DMEM_BUSY = s.dm;
        EX_IS_MUL = s.mul; EX_BR_TAKEN = s.br; EX_MEMREAD = s.mr;
        EX_RD = s.rd; ID_RS1 = s.rs1; ID_RS2 = s.rs2;
        ID_USE_RS1 = s.u1; ID_USE_RS2 = s.u2;
        if (pre) begin
            dut.stall_q = 32'hFFFF_FE00;
            m_stall = 32'hFFFF_FE00;
        end
        e.skip = s.rst; e.stall = m_stall; e.halted = m_halt;
        e.wren = 5'h1f; e.flush = 3'b000;
        if (s.rst) begin
            q.push_back(e);
            m_halt = 0; m_mul_left = 0; m_stall = '0;
            return;
        end
        hz = s.mr && s.rd != 0 &&
             ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        st = 0;
        if (m_halt || s.wbh) begin
            e.wren = '0; m_halt = 1;
        end else if (s.dm) begin
            e.wren = '0; st = 1;
        end else if (m_mul_left > 1) begin
            e.wren = 5'b00011; e.flush = 3'b001; m_mul_left--; st = 1;
        end else if (m_mul_left == 1) begin
            m_mul_left = 0;
        end else if (MUL_EN && s.mul) begin
            e.wren = 5'b00011; e.flush = 3'b001;
            m_mul_left = MUL_LAT - 1; st = 1;
        end else if (s.br) begin
            e.flush = 3'b110;
        end else if (hz) begin
            e.wren = 5'b00111; e.flush = 3'b010; st = 1;
        end
        if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.skip) begin
                check("wren", {27'd0, PC_WREN, IFID_WREN, IDEX_WREN,
                      EXMEM_WREN, MEMWB_WREN}, {27'd0, e.wren});
                check("flush", {29'd0, IFID_FLUSH, IDEX_FLUSH,
                      EXMEM_FLUSH}, {29'd0, e.flush});
                check("stall_cnt", STALL_CNT, e.stall);
                check("halted", {31'd0, HALTED}, {31'd0, e.halted});
            end
        end
    end

    initial begin
        stim_t z;
        stim_t s;
        z = '0;
        s = z; s.rst = 1; step(s); step(s);
        step(z); step(z);
        // load-use, then EX_RD=0 negative case, then branch over hazard
        s = z; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        step(s); step(z);
        s.rd = 0; step(s); step(z);
        s.rd = 5; s.br = 1; step(s); step(z);
        // multiply held in EX, then again with DMEM stalls mid-flight
        s = z; s.mul = 1;
        repeat (MUL_LAT) step(s);
        step(z);
        step(s);
        s.dm = 1; repeat (3) step(s);
        s.dm = 0; repeat (MUL_LAT - 1) step(s);
        step(z); step(z);
        // halt, toggle DMEM while frozen, reset out of it
        s = z; s.wbh = 1; step(s);
        s = z;
        for (int i = 0; i < 6; i++) begin
            s.dm = i[0]; step(s);
        end
        s = z; s.rst = 1; step(s);
        step(z); step(z);
        // saturation from a near-max preload
        s = z; s.dm = 1; step(s, 1'b1);
        repeat (1000) step(s);
        step(z); step(z);
        s = z; s.rst = 1; step(s);
        for (int i = 0; i < 2000; i++) begin
            s.rst = ($urandom_range(0, 39) == 0);
            s.wbh = ($urandom_range(0, 79) == 0);
            s.dm  = ($urandom_range(0, 5) == 0);
            s.mul = ($urandom_range(0, 7) == 0);
            s.br  = !s.mul && ($urandom_range(0, 5) == 0);
            s.mr  = ($urandom_range(0, 2) == 0);
            s.rd  = 5'($urandom_range(0, 3));
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            step(s);
        end
        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
